// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: one quotient bit per ITER cycle.
// Optional DIV_ZERO_CHECK_EN short-circuits divide-by-zero from LOAD.
module div_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz_err
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH:0]   dvs_inv;
  logic [WIDTH+1:0] sum;
  logic             carry;
  logic [WIDTH:0]   prem_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic             last;

  // Subtract as add of the inverted divisor with carry-in; carry-out means no borrow.
  always_comb begin
    prem_sh = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    dvs_inv = ~{1'b0, dvs_q};
    sum     = {1'b0, prem_sh} + {1'b0, dvs_inv}
            + (WIDTH+2)'(1);
    carry   = sum[WIDTH+1];
    prem_nx = carry ? sum[WIDTH:0] : prem_sh;
    dvd_nx  = (dvd_q << 1) | WIDTH'(carry);
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          dvd_d   = dividend;
          dvs_d   = divisor;
        end
      end
      LOAD: begin
        prem_d  = '0;
        cnt_d   = '0;
        dz_d    = 1'b0;
        state_d = ITER;
`ifdef DIV_ZERO_CHECK_EN
        if (dvs_q == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = dvd_q;
          dz_d    = 1'b1;
        end
`endif
      end
      ITER: begin
        prem_d = prem_nx;
        dvd_d  = dvd_nx;
        cnt_d  = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          quo_d   = dvd_nx;
          rem_d   = prem_nx[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q == LOAD) || (state_q == ITER);
  assign done      = (state_q == DONE);
  assign dz_err    = done && dz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer (WIDTH=8).
// Divide-by-zero expectations follow DIV_ZERO_CHECK_EN.
module tb_div_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       dz_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  div_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .dz_err   (dz_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rp: edge number at which start is re-pulsed with other operands (0 = none)
  task automatic run_op(input string tag,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input int elat, input int rp);
    int n;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    n = 1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(negedge clk);
      start = (n + 1 == rp);
      dividend = 8'd50; divisor = 8'd5;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " lat"}, 32'(n), 32'(elat));
    chk({tag, " q"}, 32'(quotient), 32'(eq));
    chk({tag, " r"}, 32'(remainder), 32'(er));
    chk({tag, " dz"}, 32'(dz_err), 32'(edz));
    chk({tag, " busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(done), 32'd0);
    chk({tag, " dz_low"}, 32'(dz_err), 32'd0);
    chk({tag, " q_hold"}, 32'(quotient), 32'(eq));
    chk({tag, " r_hold"}, 32'(remainder), 32'(er));
  endtask

  initial begin
    int dc;
    int hits[$];
    #12;
    chk("rst q", 32'(quotient), 32'd0);
    chk("rst r", 32'(remainder), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst dz", 32'(dz_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 0);
    run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 10, 0);
    run_op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 10, 0);
    run_op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 10, 0);
    run_op("0/3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 10, 0);
`ifdef DIV_ZERO_CHECK_EN
    run_op("200/0", 8'd200, 8'd0, 8'hFF, 8'hC8, 1'b1, 2, 0);
`else
    run_op("200/0", 8'd200, 8'd0, 8'hFF, 8'hC8, 1'b0, 10, 0);
`endif
    run_op("repulse", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 4);

    // Abort mid-operation with an asynchronous reset
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort q", 32'(quotient), 32'd0);
    chk("abort r", 32'(remainder), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort dz", 32'(dz_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (12) begin
      @(posedge clk); #1;
      dc += int'(done);
    end
    chk("abort no_done", 32'(dc), 32'd0);
    run_op("9/2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 10, 0);

    // Start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; dividend = 8'd20; divisor = 8'd3;
    for (int e = 1; e <= 36; e++) begin
      @(posedge clk); #1;
      if (done) begin
        hits.push_back(e);
        chk("held q", 32'(quotient), 32'd6);
        chk("held r", 32'(remainder), 32'd2);
      end
      if (e == 25) start = 1'b0;
    end
    chk("held count", 32'(hits.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("held edge", (i < hits.size()) ? 32'(hits[i]) : 32'd0,
          32'(10 + 11 * i));

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
